seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode 4-digit 7-segment display. It shares the single segment bus between digits by giving each digit a fixed time slot, with an anti-ghosting blank interval at the start of each slot. New display contents arrive over a valid/ready update port and are applied only at frame boundaries. It sits between the processor's debug/output register and the FPGA display pins, and replaces the bare refresh divider as the display's sequencer.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 32 +++
 rtl/seg7_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the active-high hex font for the 7-segment scan controller.
// Segment vectors are ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    localparam seg_t SEG_OFF = 7'b0000000;
    localparam seg_t SEG_0   = 7'b0111111;
    localparam seg_t SEG_1   = 7'b0000110;
    localparam seg_t SEG_2   = 7'b1011011;
    localparam seg_t SEG_3   = 7'b1001111;
    localparam seg_t SEG_4   = 7'b1100110;
    localparam seg_t SEG_5   = 7'b1101101;
    localparam seg_t SEG_6   = 7'b1111101;
    localparam seg_t SEG_7   = 7'b0000111;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1101111;
    localparam seg_t SEG_A   = 7'b1110111;
    localparam seg_t SEG_B   = 7'b1111100;
    localparam seg_t SEG_C   = 7'b0111001;
    localparam seg_t SEG_D   = 7'b1011110;
    localparam seg_t SEG_E   = 7'b1111001;
    localparam seg_t SEG_F   = 7'b1110001;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display with
// per-slot anti-ghost blanking and frame-synchronous double-buffered updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    scan_state_t   state, state_nxt;

    logic [4*NUM_DIGITS-1:0] act_data, sh_data;
    logic [NUM_DIGITS-1:0]   act_dp, sh_dp, act_blank, sh_blank;
    logic                    pending, commit, xfer;

    logic [3:0]            nib;
    logic [6:0]            seg_hex, seg_c;
    logic                  dp_c;
    logic [NUM_DIGITS-1:0] an_c;

    assign upd_ready = !pending;
    assign xfer      = upd_valid && !pending;
    assign commit    = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign nib       = act_data[4*idx +: 4];

    seg7_hex_decode u_dec (
        .nib (nib),
        .seg (seg_hex)
    );

    always_comb begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // State tracks the slot position of the cycle it is registered for, so
    // the pin decode below sees BLANK exactly while cnt < BLANK_CYCLES.
    always_comb begin
        state_nxt = (32'(cnt_nxt) < 32'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
        an_c      = '0;
        seg_c     = SEG_OFF;
        dp_c      = 1'b0;
        if (state == ST_DRIVE) begin
            an_c[idx] = 1'b1;
            if (!act_blank[idx]) begin
                seg_c = seg_hex;
                dp_c  = act_dp[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= ST_BLANK;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
        end
    end

    // Commit uses the pre-capture pending value; a capture on the commit
    // cycle is therefore shown one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
        end else if (commit && pending) begin
            act_data  <= sh_data;
            act_dp    <= sh_dp;
            act_blank <= sh_blank;
            pending   <= 1'b0;
        end else if (xfer) begin
            sh_data   <= upd_data;
            sh_dp     <= upd_dp;
            sh_blank  <= upd_blank;
            pending   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= {NUM_DIGITS{POL}};
            seg         <= {7{POL}};
            dp          <= POL;
            frame_start <= 1'b0;
        end else begin
            an          <= an_c ^ {NUM_DIGITS{POL}};
            seg         <= seg_c ^ {7{POL}};
            dp          <= dp_c ^ POL;
            frame_start <= commit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench: per-cycle comparison against a time-based display model
// plus hand-computed pin values at selected cycles.
module tb_seg7_scan_ctrl;

    localparam int ND   = 4;
    localparam int SLOT = 8;
    localparam int BLK  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_data = '0;
    logic [3:0]  upd_dp = '0;
    logic [3:0]  upd_blank = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int n_vec = 0;
    int n_bad = 0;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLK),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .upd_dp      (upd_dp),
        .upd_blank   (upd_blank),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Active-high {g..a} font
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model: t = cycles since reset release; display position follows from t.
    int          t;
    bit          pend;
    logic [15:0] sh_d, ac_d;
    logic [3:0]  sh_dp, ac_dp, sh_bl, ac_bl;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    int          pos, dig;
    bit          bnd, cap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; pend = 0;
            ac_d = '0; ac_dp = '0; ac_bl = '1;
            sh_d = '0; sh_dp = '0; sh_bl = '1;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            pos = t % SLOT;
            dig = (t / SLOT) % ND;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (pos >= BLK) begin
                e_an = ~(4'b0001 << dig);
                if (!ac_bl[dig]) begin
                    e_seg = ~FONT[ac_d[dig*4 +: 4]];
                    e_dp  = ~ac_dp[dig];
                end
            end
            bnd  = (pos == SLOT-1) && (dig == ND-1);
            e_fs = bnd;
            cap  = upd_valid && !pend;
            if (bnd && pend) begin
                ac_d = sh_d; ac_dp = sh_dp; ac_bl = sh_bl; pend = 0;
            end
            if (cap) begin
                sh_d = upd_data; sh_dp = upd_dp; sh_bl = upd_blank; pend = 1;
            end
            t++;
        end
    end

    always @(posedge clk) begin
        #1;
        n_vec++;
        if ({an, seg, dp, frame_start, upd_ready} !== {e_an, e_seg, e_dp, e_fs, !pend}) begin
            n_bad++;
            $display("FAIL model t=%0d got an=%b seg=%b dp=%b fs=%b rdy=%b want an=%b seg=%b dp=%b fs=%b rdy=%b",
                     t, an, seg, dp, frame_start, upd_ready, e_an, e_seg, e_dp, e_fs, !pend);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b, input logic v);
        @(negedge clk);
        rst_n = 1'b0;
        upd_data = d; upd_dp = p; upd_blank = b; upd_valid = v;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fs", 32'(frame_start), 32'h0);
        chk("rst_rdy", 32'(upd_ready), 32'h1);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge following posedge number p after release.
    task automatic to_edge(input int p);
        while (t < p) @(negedge clk);
    endtask

    initial begin
        // Reset, single update, commit at cycle 31
        restart(16'h1A3F, 4'b0100, 4'b0000, 1'b1);
        to_edge(1);  upd_valid = 1'b0;
        chk("s2_rdy_busy", 32'(upd_ready), 32'h0);
        to_edge(12); chk("s1_dark_an", 32'(an), 32'b1101); chk("s1_dark_seg", 32'(seg), 32'h7F);
        to_edge(31); chk("s2_rdy31", 32'(upd_ready), 32'h0); chk("s2_fs31", 32'(frame_start), 32'h0);
        to_edge(32); chk("s2_rdy32", 32'(upd_ready), 32'h1); chk("s2_fs32", 32'(frame_start), 32'h1);
        to_edge(34); chk("s3_blank_an", 32'(an), 32'hF);
        to_edge(35); chk("s3_first_an", 32'(an), 32'b1110);
        to_edge(36); chk("s2_d0_an", 32'(an), 32'b1110); chk("s2_d0_seg", 32'(seg), 32'b0001110);
                     chk("s2_d0_dp", 32'(dp), 32'h1);
        to_edge(44); chk("s2_d1_an", 32'(an), 32'b1101); chk("s2_d1_seg", 32'(seg), 32'b0110000);
        to_edge(52); chk("s2_d2_an", 32'(an), 32'b1011); chk("s2_d2_seg", 32'(seg), 32'b0001000);
                     chk("s2_d2_dp", 32'(dp), 32'h0);
        to_edge(60); chk("s2_d3_an", 32'(an), 32'b0111); chk("s2_d3_seg", 32'(seg), 32'b1111001);
        to_edge(68); chk("s3_rep_an", 32'(an), 32'b1110);

        // Held valid while pending, then capture on the commit cycle itself
        restart(16'h1111, 4'b0000, 4'b0000, 1'b1);
        to_edge(1);  upd_data = 16'h2222;
        to_edge(32); chk("s4_rdy32", 32'(upd_ready), 32'h1);
        to_edge(33); chk("s4_rdy33", 32'(upd_ready), 32'h0); upd_valid = 1'b0;
        to_edge(36); chk("s4_old_seg", 32'(seg), 32'b1111001);
        to_edge(68); chk("s4_new_seg", 32'(seg), 32'b0100100);
        to_edge(95); chk("s4_rdy95", 32'(upd_ready), 32'h1);
        upd_data = 16'h3333; upd_valid = 1'b1;
        to_edge(96); upd_valid = 1'b0; chk("s4_rdy96", 32'(upd_ready), 32'h0);
        to_edge(100); chk("s4_late_seg", 32'(seg), 32'b0100100);
        to_edge(128); chk("s4_rdy128", 32'(upd_ready), 32'h1);
        to_edge(132); chk("s4_shown_seg", 32'(seg), 32'b0110000);

        // Blank mask on digit 1
        restart(16'h5678, 4'b1111, 4'b0010, 1'b1);
        to_edge(1);  upd_valid = 1'b0;
        to_edge(36); chk("s5_d0_seg", 32'(seg), 32'b0000000); chk("s5_d0_dp", 32'(dp), 32'h0);
        to_edge(44); chk("s5_d1_an", 32'(an), 32'b1101); chk("s5_d1_seg", 32'(seg), 32'h7F);
                     chk("s5_d1_dp", 32'(dp), 32'h1);
        to_edge(52); chk("s5_d2_seg", 32'(seg), 32'b0000010);

        // Async reset mid-slot (cnt=5, idx=2) with an update pending
        restart(16'h9999, 4'b0000, 4'b0000, 1'b1);
        to_edge(1);  upd_valid = 1'b0;
        to_edge(21); chk("s6_pre_an", 32'(an), 32'b1011); chk("s6_pre_rdy", 32'(upd_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("s6_async_an", 32'(an), 32'hF);
        chk("s6_async_seg", 32'(seg), 32'h7F);
        chk("s6_async_dp", 32'(dp), 32'h1);
        chk("s6_async_rdy", 32'(upd_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        to_edge(4);  chk("s6_restart_an", 32'(an), 32'b1110);
        to_edge(12); chk("s6_d1_seg", 32'(seg), 32'h7F);
        to_edge(36); chk("s6_f2_seg", 32'(seg), 32'h7F); chk("s6_f2_fs", 32'(frame_start), 32'h0);
        to_edge(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
